// File: rtl/g_reg_scoreboard_pkg.sv
// Shared pipeline parameters for the general register file and its scoreboard.
// Other pipeline blocks take their data width and register count from here.
package g_reg_scoreboard_pkg;
  localparam int G_N_REG = 16;
  localparam int G_W_OPR = 32;
endpackage

// File: rtl/g_reg_pend_cnt.sv
// Saturating up/down pending-reservation counter for one register.
// clr beats inc/dec; inc together with dec holds the count.
module g_reg_pend_cnt #(
  parameter  int MAX_PEND = 3,
  localparam int W_PC     = $clog2(MAX_PEND + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  input  logic            clr,
  output logic [W_PC-1:0] count
);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && count != W_PC'(MAX_PEND)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/g_reg_scoreboard.sv
// General register file with per-register pending-writeback scoreboard.
// Define G_REG_BYPASS_EN to forward same-cycle writeback data to the read ports.
module g_reg_scoreboard
  import g_reg_scoreboard_pkg::*;
#(
  parameter  int N_REG    = G_N_REG,
  parameter  int W_OPR    = G_W_OPR,
  parameter  int N_RP     = 2,
  parameter  int MAX_PEND = 3,
  localparam int W_RD     = $clog2(N_REG),
  localparam int W_PC     = $clog2(MAX_PEND + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_RP*W_RD-1:0]  rd_addr_i,
  output logic [N_RP*W_OPR-1:0] rd_data_o,
  output logic [N_RP-1:0]       reserved_o,
  input  logic                  w_reserve_i,
  input  logic [W_RD-1:0]       w_reserve_r_i,
  output logic                  reserve_ack_o,
  input  logic                  wb_i,
  input  logic [W_RD-1:0]       wb_r_i,
  input  logic [W_OPR-1:0]      result_i,
  input  logic                  flush_i
);

  logic [W_OPR-1:0] regs [N_REG];
  logic [W_PC-1:0]  pend [N_REG];

  // A full counter can still accept when a same-cycle writeback frees a slot.
  assign reserve_ack_o = w_reserve_i && !flush_i &&
                         (pend[w_reserve_r_i] < W_PC'(MAX_PEND) ||
                          (wb_i && wb_r_i == w_reserve_r_i));

  for (genvar i = 0; i < N_REG; i++) begin : g_cnt
    g_reg_pend_cnt #(.MAX_PEND(MAX_PEND)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (reserve_ack_o && w_reserve_r_i == W_RD'(i)),
      .dec   (wb_i && wb_r_i == W_RD'(i)),
      .clr   (flush_i),
      .count (pend[i])
    );
  end

  // NOTE: the data array is reset explicitly because reads after reset must return 0;
  // this costs a reset net on every bit and would not map to a RAM macro.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_REG; i++) regs[i] <= '0;
    end else if (wb_i) begin
      regs[wb_r_i] <= result_i;
    end
  end

  // NOTE: every output of this block gets a default before any conditional override,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    rd_data_o  = '0;
    reserved_o = '0;
    for (int p = 0; p < N_RP; p++) begin
      rd_data_o[p*W_OPR +: W_OPR] = regs[rd_addr_i[p*W_RD +: W_RD]];
      reserved_o[p]               = pend[rd_addr_i[p*W_RD +: W_RD]] != '0;
`ifdef G_REG_BYPASS_EN
      if (wb_i && rd_addr_i[p*W_RD +: W_RD] == wb_r_i) begin
        rd_data_o[p*W_OPR +: W_OPR] = result_i;
        if (pend[wb_r_i] == W_PC'(1) && !(reserve_ack_o && w_reserve_r_i == wb_r_i))
          reserved_o[p] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_g_reg_scoreboard.sv
// Self-checking bench for g_reg_scoreboard: per-cycle reference model plus directed literal checks.
// Build with G_REG_BYPASS_EN defined to exercise the forwarding variant.
module tb_g_reg_scoreboard;
  localparam int N_REG = 16, W_OPR = 32, N_RP = 2, MAX_PEND = 3, W_RD = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_RP*W_RD-1:0]  rd_addr;
  logic [N_RP*W_OPR-1:0] rd_data;
  logic [N_RP-1:0]       reserved;
  logic                  w_reserve;
  logic [W_RD-1:0]       w_reserve_r;
  logic                  reserve_ack;
  logic                  wb;
  logic [W_RD-1:0]       wb_r;
  logic [W_OPR-1:0]      result;
  logic                  flush;

  int n_tests = 0;
  int n_fail  = 0;
  bit model_ok = 1'b0;

  logic [W_OPR-1:0] m_data [N_REG];
  int               m_pend [N_REG];

  always #5 clk = ~clk;

  g_reg_scoreboard #(.N_REG(N_REG), .W_OPR(W_OPR), .N_RP(N_RP), .MAX_PEND(MAX_PEND)) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .reserved_o    (reserved),
    .w_reserve_i   (w_reserve),
    .w_reserve_r_i (w_reserve_r),
    .reserve_ack_o (reserve_ack),
    .wb_i          (wb),
    .wb_r_i        (wb_r),
    .result_i      (result),
    .flush_i       (flush)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ack();
    return w_reserve && !flush &&
           (m_pend[w_reserve_r] < MAX_PEND || (wb && wb_r == w_reserve_r));
  endfunction

  // Reference model: state advances on each rising edge from the stable inputs.
  always @(posedge clk) begin
    bit ack;
    ack = model_ack();
    for (int i = 0; i < N_REG; i++) begin
      int p;
      p = m_pend[i];
      if (ack && w_reserve_r == i) p = p + 1;
      if (wb && wb_r == i && p > 0) p = p - 1;
      if (!reset) begin
        m_data[i] <= '0;
        m_pend[i] <= 0;
      end else begin
        if (wb && wb_r == i) m_data[i] <= result;
        m_pend[i] <= flush ? 0 : p;
      end
    end
  end

  // Compare process: every falling edge once the model state is defined.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int p = 0; p < N_RP; p++) begin
        logic [W_RD-1:0]  a;
        logic [W_OPR-1:0] ed;
        logic             er;
        a  = rd_addr[p*W_RD +: W_RD];
        ed = m_data[a];
        er = m_pend[a] != 0;
`ifdef G_REG_BYPASS_EN
        if (wb && wb_r == a) begin
          ed = result;
          if (m_pend[a] == 1 && !(model_ack() && w_reserve_r == a)) er = 1'b0;
        end
`endif
        check($sformatf("model_data_p%0d", p), 64'(rd_data[p*W_OPR +: W_OPR]), 64'(ed));
        check($sformatf("model_rsv_p%0d", p), 64'(reserved[p]), 64'(er));
      end
      check("model_ack", 64'(reserve_ack), 64'(model_ack()));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    w_reserve = 1'b0;
    wb        = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic read2(input int a0, input int a1);
    rd_addr = {W_RD'(a1), W_RD'(a0)};
  endtask

  task automatic reserve(input int r);
    w_reserve   = 1'b1;
    w_reserve_r = W_RD'(r);
  endtask

  task automatic writeback(input int r, input logic [W_OPR-1:0] d);
    wb     = 1'b1;
    wb_r   = W_RD'(r);
    result = d;
  endtask

  function automatic logic [W_OPR-1:0] port(input int p);
    return rd_data[p*W_OPR +: W_OPR];
  endfunction

  initial begin
    reset = 1'b0; rd_addr = '0; w_reserve = 1'b0; w_reserve_r = '0;
    wb = 1'b0; wb_r = '0; result = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_ok = 1'b1;
    reset    = 1'b1;

    // All registers read zero and unreserved after reset.
    for (int r = 0; r < N_REG; r++) begin
      read2(r, r);
      @(negedge clk);
      check("rst_data0", 64'(port(0)), 64'h0);
      check("rst_data1", 64'(port(1)), 64'h0);
      check("rst_rsv", 64'(reserved), 64'h0);
    end

    // Reserve r2, then write it back.
    next_cycle();
    reserve(2);
    @(negedge clk);
    check("r2_ack", 64'(reserve_ack), 64'h1);
    next_cycle();
    read2(2, 2);
    @(negedge clk);
    check("r2_rsv", 64'(reserved), 64'h3);
    next_cycle();
    writeback(2, 32'h0000_00AA);
    @(negedge clk);
`ifdef G_REG_BYPASS_EN
    check("r2_byp_data", 64'(port(1)), 64'hAA);
    check("r2_byp_rsv", 64'(reserved), 64'h0);
`else
    check("r2_wb_data_old", 64'(port(1)), 64'h0);
    check("r2_wb_rsv_old", 64'(reserved), 64'h3);
`endif
    next_cycle();
    @(negedge clk);
    check("r2_data", 64'(port(0)), 64'hAA);
    check("r2_rsv_clr", 64'(reserved), 64'h0);

    // Saturation at MAX_PEND on r5, then drain.
    read2(5, 5);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      reserve(5);
      @(negedge clk);
      check($sformatf("r5_ack%0d", k), 64'(reserve_ack), (k < 3) ? 64'h1 : 64'h0);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      writeback(5, 32'h500 + 32'(k));
      next_cycle();
      @(negedge clk);
      check($sformatf("r5_rsv%0d", k), 64'(reserved), (k < 2) ? 64'h3 : 64'h0);
    end
    check("r5_data", 64'(port(0)), 64'h502);

    // Full counter accepts a reservation when a same-cycle writeback frees a slot.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      reserve(6);
    end
    next_cycle();
    reserve(6);
    writeback(6, 32'h66);
    read2(6, 6);
    @(negedge clk);
    check("r6_full_ack", 64'(reserve_ack), 64'h1);

    // Same-cycle reserve and writeback on r3 with pend=1.
    next_cycle();
    reserve(3);
    next_cycle();
    reserve(3);
    writeback(3, 32'h1234);
    read2(3, 0);
    @(negedge clk);
    check("r3_ack", 64'(reserve_ack), 64'h1);
    next_cycle();
    @(negedge clk);
    check("r3_data", 64'(port(0)), 64'h1234);
    check("r3_rsv", 64'(reserved), 64'h1);

    // Reserve and writeback to different registers in one cycle.
    next_cycle();
    reserve(10);
    writeback(11, 32'hBEEF);
    read2(10, 11);
    next_cycle();
    @(negedge clk);
    check("r10_r11_rsv", 64'(reserved), 64'h1);
    check("r11_data", 64'(port(1)), 64'hBEEF);

    // Flush with concurrent writeback and dropped reservation.
    next_cycle();
    reserve(1);
    next_cycle();
    reserve(1);
    next_cycle();
    reserve(7);
    next_cycle();
    read2(1, 7);
    @(negedge clk);
    check("pre_flush_rsv", 64'(reserved), 64'h3);
    flush = 1'b1;
    writeback(1, 32'h55);
    reserve(4);
    @(negedge clk);
    check("flush_ack", 64'(reserve_ack), 64'h0);
    next_cycle();
    @(negedge clk);
    check("flush_rsv_1_7", 64'(reserved), 64'h0);
    check("flush_r1_data", 64'(port(0)), 64'h55);
    read2(4, 3);
    @(negedge clk);
    check("flush_rsv_4_3", 64'(reserved), 64'h0);

    // Reset mid-operation discards reservations and data.
    next_cycle();
    reserve(9);
    next_cycle();
    read2(9, 1);
    @(negedge clk);
    check("r9_rsv_pre", 64'(reserved), 64'h1);
    reset = 1'b0;
    reserve(9);
    writeback(1, 32'hDEAD);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("r9_rst_rsv", 64'(reserved), 64'h0);
    check("r1_rst_data", 64'(port(1)), 64'h0);
    writeback(9, 32'h77);
    next_cycle();
    @(negedge clk);
    check("r9_stale_data", 64'(port(0)), 64'h77);
    check("r9_stale_rsv", 64'(reserved), 64'h0);

    next_cycle();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/g_reg_scoreboard.md
G_REG_SCOREBOARD -- requirements
Module: g_reg_scoreboard

Interface
REQ-001 The block SHALL have parameter N_REG, default 16, meaning number of general registers (power of two, 2..64).
REQ-002 The block SHALL have parameter W_OPR, default 32, meaning register data width.
REQ-003 The block SHALL have parameter N_RP, default 2, meaning number of read ports (1..4).
REQ-004 The block SHALL have parameter MAX_PEND, default 3, meaning maximum outstanding reservations per register (1..7).
REQ-005 The block SHALL have localparam W_RD = clog2(N_REG) and W_PC = clog2(MAX_PEND+1).
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-008 The block SHALL have port rd_addr_i, input, N_RP*W_RD, read addresses, port p in bits [p*W_RD +: W_RD].
REQ-009 The block SHALL have port rd_data_o, output, N_RP*W_OPR, read data per port.
REQ-010 The block SHALL have port reserved_o, output, N_RP, per-port busy flag (operand not yet written back).
REQ-011 The block SHALL have ports w_reserve_i (1) and w_reserve_r_i (W_RD), inputs, destination reservation request and index.
REQ-012 The block SHALL have port reserve_ack_o, output, 1, combinational acceptance of the current reservation.
REQ-013 The block SHALL have ports wb_i (1), wb_r_i (W_RD), result_i (W_OPR), inputs, writeback strobe, index, data.
REQ-014 The block SHALL have port flush_i, input, 1, clears all pending counts (used after a pipeline drain on branch).

Function
REQ-015 Each register SHALL hold a W_OPR data word and a W_PC pending counter.
REQ-016 Read SHALL be combinational: rd_data_o[p] = reg[rd_addr_i[p]], reserved_o[p] = (pend[rd_addr_i[p]] != 0).
REQ-017 On wb_i, reg[wb_r_i] SHALL take result_i at the next edge; pend[wb_r_i] SHALL decrement, saturating at 0.
REQ-018 reserve_ack_o SHALL be w_reserve_i & ~flush_i & (pend[w_reserve_r_i] < MAX_PEND, or a same-cycle wb_i to that index); when acked, pend SHALL increment at the next edge.
REQ-019 An unacked reservation SHALL leave state unchanged; the requester holds the request (decode stalls).
REQ-020 Reserve and wb_i to the same index in one cycle SHALL leave pend unchanged and still write the data.
REQ-021 Reserve and wb_i to different indices SHALL both take effect in the same cycle.
REQ-022 flush_i SHALL zero every counter at the next edge; a same-cycle wb_i SHALL still write data; a same-cycle reserve SHALL be dropped (ack=0).
REQ-023 Multiple read ports addressing the same register SHALL return identical data and flags.
REQ-024 Writeback with pend=0 (stale) SHALL write data and leave pend at 0.

Reset
REQ-025 While reset=0 at a rising edge, all data words and all counters SHALL become 0; reset SHALL override wb_i, w_reserve_i, flush_i.
REQ-026 After reset, rd_data_o SHALL read 0, reserved_o SHALL be all 0, and reserve_ack_o SHALL follow REQ-018.
REQ-027 Reset asserted mid-operation SHALL discard all outstanding reservations without requiring a matching writeback.

Configuration
REQ-028 With macro G_REG_BYPASS_EN defined, a read port whose address equals wb_r_i while wb_i=1 SHALL output result_i, and SHALL report reserved_o=0 when pend==1 and there is no same-cycle acked reservation to that index.
REQ-029 Without G_REG_BYPASS_EN, reads SHALL reflect only registered state (REQ-016), with one-cycle writeback-to-read latency.

Structure
REQ-030 W_OPR, W_RD and the default N_REG SHALL come from the shared params include used by the pipeline; MAX_PEND and N_RP SHALL stay local parameters.
REQ-031 One sub-module, g_reg_pend_cnt (a saturating up/down counter with inc, dec, clr), SHALL be instantiated N_REG times; read muxing SHALL stay in the top.
REQ-032 Registers SHALL be exposed as a hierarchically visible array for bench dumps.

Verification
REQ-033 Reset, then read all 16 registers on both ports -> data 0, reserved_o=00.
REQ-034 Reserve r2, next cycle read r2 -> reserved_o=1; wb r2=0x0000_00AA -> next cycle data 0xAA, reserved_o=0 (bypass build: same cycle).
REQ-035 Reserve r5 four times with MAX_PEND=3 -> acks 1,1,1,0; three writebacks -> reserved clears only after the third.
REQ-036 With pend[r3]=1, reserve r3 and wb r3=0x1234 in one cycle -> pend stays 1, data 0x1234, ack=1.
REQ-037 With pend r1=2, r7=1, assert flush_i together with wb r1=0x55 and reserve r4 -> all counts 0, r1=0x55, ack=0.
REQ-038 Reserve r9, assert reset=0 for one cycle -> pend and data zero; a subsequent wb r9 leaves pend 0 (REQ-024).
